// File: rtl/bcd_pkg.sv
// Shared types and constants for the streaming binary-to-BCD converter.
// Holds the FSM encoding, BCD digit constants and the counter-width helper.
package bcd_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADD    = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_ADD    = S_ADD,
        ST_SHIFT  = S_SHIFT,
        ST_FINISH = S_FINISH,
        ST_DONE   = S_DONE
    } bcd_state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int ADD3_THRESHOLD = 5;

    // The counter must be able to count up to DATA_WIDTH shifts.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adj
);

    // Add-3 correction, wrapping within the 4-bit digit.
    always_comb begin
        adj = digit;
        if (digit >= BCD_DIGIT_W'(ADD3_THRESHOLD)) begin
            adj = digit + BCD_DIGIT_W'(3);
        end else begin
            adj = digit;
        end
    end

endmodule

// File: rtl/bcd_convert_stream.sv
// Streaming binary-to-BCD converter with valid/ready on both sides, optional sign,
// overflow saturation and leading-zero blank flags for the 7-segment digit mux.
module bcd_convert_stream
    import bcd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIGITS     = 3,
    parameter int SIGNED_EN  = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]             out_blank,
    output logic                          out_neg,
    output logic                          out_ovf,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int CNT_W = cnt_width(DATA_WIDTH);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1'b1);

    bcd_state_t             state_r;
    bcd_state_t             state_next_s;
    logic [DATA_WIDTH-1:0]  shift_r;
    logic [BCD_W-1:0]       scratch_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   ovf_r;
    logic                   sign_r;

    logic                   neg_in_s;
    logic [DATA_WIDTH-1:0]  mag_s;
    logic [BCD_W-1:0]       scratch_adj_s;
    logic [BCD_W-1:0]       nines_s;
    logic [BCD_W-1:0]       final_bcd_s;
    logic [DIGITS-1:0]      final_blank_s;
    logic                   final_neg_s;
    logic                   last_bit_s;
    logic                   all_zero_v;

    assign in_ready   = (state_r == ST_IDLE);
    assign last_bit_s = (cnt_r == CNT_W'(DATA_WIDTH - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (scratch_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adj   (scratch_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Input magnitude; the most-negative value negates to 2^(DATA_WIDTH-1), still unsigned-representable.
    always_comb begin
        neg_in_s = (SIGNED_EN != 0) && in_data[DATA_WIDTH-1];
        mag_s    = in_data;
        if (neg_in_s) begin
            mag_s = ~in_data + DATA_WIDTH'(1'b1);
        end else begin
            mag_s = in_data;
        end
    end

    // Final result: saturation, sign suppression for zero, and leading-zero flags.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            nines_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
        end
        final_bcd_s = scratch_r;
        if (ovf_r) begin
            final_bcd_s = nines_s;
        end else begin
            final_bcd_s = scratch_r;
        end
        final_neg_s   = sign_r && (ovf_r || (scratch_r != '0));
        final_blank_s = '0;
        all_zero_v    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero_v       = all_zero_v && (final_bcd_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            final_blank_s[i] = all_zero_v;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_ADD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADD:    state_next_s = ST_SHIFT;
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_ADD;
                end
            end
            ST_FINISH: state_next_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Conversion datapath: shift register, BCD scratch, bit counter and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_r   <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            ovf_r     <= 1'b0;
            sign_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        shift_r   <= mag_s;
                        scratch_r <= '0;
                        cnt_r     <= '0;
                        ovf_r     <= 1'b0;
                        sign_r    <= neg_in_s;
                    end
                end
                ST_ADD: begin
                    scratch_r <= scratch_adj_s;
                end
                ST_SHIFT: begin
                    {scratch_r, shift_r} <= {scratch_r[BCD_W-2:0], shift_r, 1'b0};
                    // A set bit leaving the top digit means the value no longer fits.
                    if (scratch_r[BCD_W-1]) begin
                        ovf_r <= 1'b1;
                    end
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers; values persist after the handshake to keep the display steady.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_bcd   <= '0;
            out_blank <= BLANK_RST;
            out_neg   <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_FINISH: begin
                    out_bcd   <= final_bcd_s;
                    out_blank <= final_blank_s;
                    out_neg   <= final_neg_s;
                    out_ovf   <= ovf_r;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
